// File: rtl/sga_tx_status.sv
// UART transmitter of a 5-character game status message: 'S', size as two hex digits, status, LF.
// Define SGA_TX_PARITY_EN to add an even parity bit to every character (8E1 instead of 8N1).
module sga_tx_status #(
    parameter int unsigned BAUD_DIV = 434
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       inicio_transmissao,
    input  logic [7:0] size,
    input  logic       won,
    input  logic       lost,
    input  logic       pause,
    output logic       saida_serial,
    output logic       ocupado,
    output logic       pronto,
    output logic [2:0] db_estado
);

    localparam logic [2:0] StIdle     = 3'd0;
    localparam logic [2:0] StCarrega  = 3'd1;
    localparam logic [2:0] StStart    = 3'd2;
    localparam logic [2:0] StDados    = 3'd3;
    localparam logic [2:0] StParidade = 3'd4;
    localparam logic [2:0] StStop     = 3'd5;
    localparam logic [2:0] StProximo  = 3'd6;
    localparam logic [2:0] StFim      = 3'd7;

    localparam logic [9:0] BaudLast = 10'(BAUD_DIV - 1);

    logic [2:0]      state_q, state_d;
    logic [9:0]      baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [2:0]      idx_q, idx_d;
    logic [4:0][7:0] msg_q, msg_d;
    logic [7:0]      status_char;
    logic [7:0]      cur_char;
    logic            baud_end;

    function automatic logic [7:0] hex_char(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end
        return 8'h37 + {4'h0, nib};
    endfunction

    always_comb begin
        if (won) begin
            status_char = 8'h47;
        end else if (lost) begin
            status_char = 8'h44;
        end else if (pause) begin
            status_char = 8'h50;
        end else begin
            status_char = 8'h4A;
        end
    end

    always_comb begin
        cur_char = msg_q[0];
        case (idx_q)
            3'd1:    cur_char = msg_q[1];
            3'd2:    cur_char = msg_q[2];
            3'd3:    cur_char = msg_q[3];
            3'd4:    cur_char = msg_q[4];
            default: cur_char = msg_q[0];
        endcase
    end

    assign baud_end = (baud_q == BaudLast);

    // The baud counter runs freely and is cleared explicitly on every state change.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q + 10'd1;
        bit_d   = bit_q;
        idx_d   = idx_q;
        msg_d   = msg_q;
        case (state_q)
            StIdle: begin
                baud_d = '0;
                if (inicio_transmissao) begin
                    state_d = StCarrega;
                end
            end
            StCarrega: begin
                msg_d   = {8'h0A, status_char, hex_char(size[3:0]), hex_char(size[7:4]), 8'h53};
                idx_d   = '0;
                bit_d   = '0;
                baud_d  = '0;
                state_d = StStart;
            end
            StStart: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = StDados;
                end
            end
            StDados: begin
                if (baud_end) begin
                    baud_d = '0;
                    bit_d  = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef SGA_TX_PARITY_EN
                        state_d = StParidade;
`else
                        state_d = StStop;
`endif
                    end
                end
            end
            StParidade: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = StStop;
                end
            end
            StStop: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = StProximo;
                end
            end
            StProximo: begin
                baud_d = '0;
                if (idx_q == 3'd4) begin
                    state_d = StFim;
                end else begin
                    idx_d   = idx_q + 3'd1;
                    state_d = StStart;
                end
            end
            StFim: begin
                baud_d  = '0;
                state_d = StIdle;
            end
            default: begin
                baud_d  = '0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            baud_q  <= '0;
            bit_q   <= '0;
            idx_q   <= '0;
            msg_q   <= '0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            idx_q   <= idx_d;
            msg_q   <= msg_d;
        end
    end

    // Outputs decode registered state only, so no input reaches an output combinationally.
    always_comb begin
        case (state_q)
            StStart:    saida_serial = 1'b0;
            StDados:    saida_serial = cur_char[bit_q];
            StParidade: saida_serial = ^cur_char;
            default:    saida_serial = 1'b1;
        endcase
    end

    assign ocupado   = (state_q != StIdle) && (state_q != StFim);
    assign pronto    = (state_q == StFim);
    assign db_estado = state_q;

endmodule

// File: tb/tb_sga_tx_status.sv
// Scoreboard bench for sga_tx_status: a UART line decoder and a message-timing monitor
// pop expected bytes and lengths pushed by the stimulus from a reference message model.
module tb_sga_tx_status;

    localparam int B = 4;
`ifdef SGA_TX_PARITY_EN
    localparam int Par = 1;
`else
    localparam int Par = 0;
`endif
    localparam int FrameBits = 10 + Par;
    localparam int MsgLen    = 5 * (FrameBits * B + 1) + 2;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       inicio = 1'b0;
    logic [7:0] size = 8'h00;
    logic       won = 1'b0;
    logic       lost = 1'b0;
    logic       pause = 1'b0;
    logic       saida;
    logic       ocupado;
    logic       pronto;
    logic [2:0] db;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit held = 1'b0;

    byte unsigned exp_q[$];
    int           len_q[$];

    sga_tx_status #(
        .BAUD_DIV(B)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .inicio_transmissao (inicio),
        .size               (size),
        .won                (won),
        .lost               (lost),
        .pause              (pause),
        .saida_serial       (saida),
        .ocupado            (ocupado),
        .pronto             (pronto),
        .db_estado          (db)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference message: 'S', hex digits of size, status letter by priority, LF.
    function automatic void push_msg(input logic [7:0] sz, input logic w, input logic l,
                                     input logic p);
        string hx;
        string st;
        int    si;
        hx = "0123456789ABCDEF";
        st = "GDPJ";
        si = w ? 0 : (l ? 1 : (p ? 2 : 3));
        exp_q.push_back(8'h53);
        exp_q.push_back(hx[int'(sz[7:4])]);
        exp_q.push_back(hx[int'(sz[3:0])]);
        exp_q.push_back(st[si]);
        exp_q.push_back(8'h0A);
        len_q.push_back(MsgLen);
    endfunction

    task automatic wait_pronto(input int lim);
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!pronto && n < lim);
        if (!pronto) begin
            total++;
            bad++;
            $display("FAIL pronto_timeout: no pronto within %0d cycles", lim);
        end
    endtask

    task automatic send(input logic [7:0] sz, input logic w, input logic l, input logic p);
        @(negedge clock);
        size   = sz;
        won    = w;
        lost   = l;
        pause  = p;
        inicio = 1'b1;
        push_msg(sz, w, l, p);
        @(negedge clock);
        inicio = 1'b0;
        wait_pronto(MsgLen + 20);
    endtask

    // Line decoder: samples each bit in the middle of its period.
    initial begin : decoder
        bit           busy;
        int           cnt;
        int           k;
        logic [7:0]   sh;
        logic         pb;
        byte unsigned e;
        busy = 1'b0;
        cnt  = 0;
        sh   = '0;
        pb   = 1'b0;
        forever begin
            @(negedge clock);
            if (reset) begin
                busy = 1'b0;
            end else begin
                if (!busy && saida == 1'b0) begin
                    busy = 1'b1;
                    cnt  = 0;
                end
                if (busy) begin
                    if (cnt % B == B / 2) begin
                        k = cnt / B;
                        if (k == 0) begin
                            check("start_bit", int'(saida), 0);
                        end else if (k <= 8) begin
                            sh[k-1] = saida;
                        end else if (k < FrameBits - 1) begin
                            pb = saida;
                        end else begin
                            check("stop_bit", int'(saida), 1);
                            if (exp_q.size() == 0) begin
                                total++;
                                bad++;
                                $display("FAIL unexpected_byte: got %02h, none expected", sh);
                            end else begin
                                e = exp_q.pop_front();
                                check("byte", int'(sh), int'(e));
`ifdef SGA_TX_PARITY_EN
                                check("parity_bit", int'(pb), int'(^e));
`endif
                            end
                            busy = 1'b0;
                        end
                    end
                    cnt++;
                end
            end
        end
    end

    // Message-level monitor: length, ocupado span, parity-state usage, held-request gap.
    initial begin : msg_mon
        int start;
        int ocnt;
        int since;
        int ev;
        bit saw4;
        start = 0;
        ocnt  = 0;
        since = 1000;
        saw4  = 1'b0;
        forever begin
            @(negedge clock);
            since++;
            if (db == 3'd1) begin
                start = cyc;
                ocnt  = 0;
                saw4  = 1'b0;
                if (held && since < 100) check("held_gap", since, 2);
            end
            if (ocupado) ocnt++;
            if (db == 3'd4) saw4 = 1'b1;
            if (pronto) begin
                check("pronto_ocupado_low", int'(ocupado), 0);
                if (len_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_pronto: pulse at cycle %0d, none expected", cyc);
                end else begin
                    ev = len_q.pop_front();
                    check("msg_len", cyc - start + 1, ev);
                    check("ocupado_cycles", ocnt, ev - 1);
                    check("parity_state_seen", int'(saw4), Par);
                end
                since = 0;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check("reset_line", int'(saida), 1);
        check("reset_ocupado", int'(ocupado), 0);
        check("reset_pronto", int'(pronto), 0);
        check("reset_state", int'(db), 0);
        reset = 1'b0;

        send(8'h2B, 1'b0, 1'b0, 1'b0);
        send(8'h2B, 1'b1, 1'b1, 1'b0);
        send(8'h2B, 1'b0, 1'b0, 1'b1);
        send(8'h07, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            send(8'($urandom_range(0, 255)), 1'($urandom), 1'($urandom), 1'($urandom));
        end

        // Size changes during the second character must not alter the latched message.
        @(negedge clock);
        size   = 8'h2B;
        won    = 1'b0;
        lost   = 1'b0;
        pause  = 1'b0;
        inicio = 1'b1;
        push_msg(8'h2B, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        inicio = 1'b0;
        repeat (60) @(negedge clock);
        size = 8'hFF;
        wait_pronto(MsgLen + 20);
        send(8'hFF, 1'b0, 1'b0, 1'b0);

        // Held request: three back-to-back messages.
        @(negedge clock);
        size   = 8'hA5;
        pause  = 1'b1;
        held   = 1'b1;
        inicio = 1'b1;
        for (int i = 0; i < 3; i++) push_msg(8'hA5, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) wait_pronto(MsgLen + 20);
        inicio = 1'b0;
        held   = 1'b0;

        // Reset during bit 3 of character 2.
        @(negedge clock);
        size   = 8'h3C;
        pause  = 1'b0;
        inicio = 1'b1;
        push_msg(8'h3C, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        inicio = 1'b0;
        repeat (99) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("midreset_line", int'(saida), 1);
        check("midreset_state", int'(db), 0);
        check("midreset_pronto", int'(pronto), 0);
        check("midreset_ocupado", int'(ocupado), 0);
        @(negedge clock);
        reset = 1'b0;
        exp_q.delete();
        len_q.delete();
        repeat (50) @(negedge clock);
        send(8'h3C, 1'b0, 1'b0, 1'b0);
        send(8'($urandom_range(0, 255)), 1'($urandom), 1'($urandom), 1'($urandom));

        repeat (20) @(negedge clock);
        check("bytes_outstanding", exp_q.size(), 0);
        check("msgs_outstanding", len_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sga_tx_status.md
SGA_TX_STATUS -- requirements
Module: sga_tx_status

Interface
REQ-001 The block SHALL have one parameter, BAUD_DIV: default 434; number of clock cycles per serial bit (115200 baud at 50 MHz); legal range 2..1023.
REQ-002 The `clock` port SHALL be an input, 1 bit wide: system clock; all logic updates on the rising edge.
REQ-003 The `reset` port SHALL be an input, 1 bit wide: synchronous, active-high reset.
REQ-004 The `inicio_transmissao` port SHALL be an input, 1 bit wide: level request from the control unit to send one status message.
REQ-005 The `size` port SHALL be an input, 8 bits wide: current snake size, sent as two hex digits.
REQ-006 The `won`, `lost` and `pause` ports SHALL each be an input, 1 bit wide: game status flags.
REQ-007 The `saida_serial` port SHALL be an output, 1 bit wide: UART TX line, idle high, LSB first.
REQ-008 The `ocupado` port SHALL be an output, 1 bit wide: high from CARREGA through the last stop bit.
REQ-009 The `pronto` port SHALL be an output, 1 bit wide: one-cycle pulse when a complete message has been sent.
REQ-010 The `db_estado` port SHALL be an output, 3 bits wide: encoding of the current FSM state.

Function
REQ-011 The FSM SHALL have the states IDLE=0, CARREGA=1, START=2, DADOS=3, PARIDADE=4, STOP=5, PROXIMO=6 and FIM=7, and db_estado SHALL equal the state code.
REQ-012 IDLE: saida_serial=1 and ocupado=0; the FSM SHALL go to CARREGA on the edge that samples inicio_transmissao=1, and stay in IDLE otherwise.
REQ-013 CARREGA (one cycle): the block SHALL latch the 5-character message and clear the character index to 0; inputs that change later SHALL NOT affect the message.
REQ-014 Message characters, in order:
- 'S' (0x53)
- ASCII hex of size[7:4]
- ASCII hex of size[3:0]
- status character
- LF (0x0A)
REQ-015 Hex digits SHALL use 0x30-0x39 for 0-9 and uppercase 0x41-0x46 for A-F.
REQ-016 The status character SHALL use priority won > lost > pause > playing: 'G' (0x47), 'D' (0x44), 'P' (0x50), 'J' (0x4A).
REQ-017 START SHALL drive saida_serial=0 for exactly BAUD_DIV cycles.
REQ-018 DADOS SHALL drive 8 data bits, LSB first, each for exactly BAUD_DIV cycles, using a 3-bit bit counter.
REQ-019 After DADOS the FSM SHALL go to PARIDADE when parity is compiled in (see Configuration), and to STOP otherwise.
REQ-020 STOP SHALL drive saida_serial=1 for exactly BAUD_DIV cycles.
REQ-021 PROXIMO (one cycle, line high): if the character index is 4, the FSM SHALL go to FIM; otherwise it SHALL increment the index and go to START.
REQ-022 FIM (one cycle) SHALL assert pronto=1, deassert ocupado, and return to IDLE.
REQ-023 A request that is still high in IDLE after FIM SHALL start a new message, so a held level retransmits with at least one idle cycle between messages.
REQ-024 The baud counter SHALL be 10 bits wide, SHALL clear on every state change, and the bit period SHALL end when the count reaches BAUD_DIV-1.
REQ-025 Without parity, one message SHALL occupy exactly 5*(10*BAUD_DIV+1)+2 cycles from CARREGA through FIM inclusive.
REQ-026 inicio_transmissao SHALL be ignored in every state except IDLE; a message in progress cannot be aborted except by reset.
REQ-027 All outputs SHALL be registered, or decoded from the registered state only, with no combinational path from any input to any output.

Reset
REQ-028 While reset=1 at a rising edge, the state SHALL become IDLE, all counters and the message register SHALL clear, and the outputs SHALL be saida_serial=1, ocupado=0, pronto=0 and db_estado=0.
REQ-029 Reset asserted mid-character SHALL return the line high on the next edge with no partial stop bit, and pronto SHALL NOT pulse.
REQ-030 Reset SHALL take priority over inicio_transmissao on the same edge.

Configuration
REQ-031 With the macro SGA_TX_PARITY_EN defined, every character SHALL carry an even parity bit, held for BAUD_DIV cycles in PARIDADE between the data bits and the stop bit (8E1 frames).
REQ-032 With SGA_TX_PARITY_EN defined, the message length SHALL be 5*(11*BAUD_DIV+1)+2 cycles.
REQ-033 With SGA_TX_PARITY_EN undefined, PARIDADE SHALL be unreachable, frames SHALL be 8N1, and db_estado SHALL never read 4.

Verification
REQ-034 Basic message: BAUD_DIV=4, parity off, size=0x2B, all flags 0, one-cycle request -> the line decodes to 0x53 0x32 0x42 0x4A 0x0A; pronto pulses exactly 5*(41)+2=207 cycles after the request edge's CARREGA; ocupado is high for 206 cycles.
REQ-035 Status priority: won=1 and lost=1 together -> status character is 0x47; with only pause=1 -> 0x50.
REQ-036 Latching: size changes from 0x2B to 0xFF during the second character -> the message still carries '2','B'; the next message carries 'F','F'.
REQ-037 Held request: inicio_transmissao held high for 3 messages -> three back-to-back messages, each separated by exactly one idle-high cycle after FIM.
REQ-038 Reset mid-frame: reset during bit 3 of character 2 -> on the next edge saida_serial=1 and db_estado=0, pronto never pulses, and a following request sends a full correct message.
REQ-039 Parity build: with SGA_TX_PARITY_EN defined and size=0x07 -> the character '7' (0x37, five ones) carries parity bit 1, and the total message length is 227 cycles for BAUD_DIV=4.
